// File: rtl/word_scan_sequencer.sv
// Purpose : sweeps the mux select over all source words and streams each captured word out.
// Latency : start edge -> first out_valid two edges later; one bubble cycle between words.
// Backpres: out_data/out_index held while out_ready is low; the sweep stalls on that word.
// Optional: define SCAN_AUTO_CYCLE_EN to restart a sweep DWELL_CYCLES idle cycles after done.
module word_scan_sequencer #(
  parameter int NUM_SRC      = 9,
  parameter int SEL_W        = 4,
  parameter int DATA_W       = 32,
  parameter int DWELL_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] sel_data,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SELECT, PRESENT} state_t;

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_SRC - 1);

  // Reject parameter sets the select register or dwell counter cannot represent.
  if (NUM_SRC < 1 || NUM_SRC > (1 << SEL_W)) begin : g_bad_num_src
    $error("word_scan_sequencer: NUM_SRC does not fit in SEL_W select bits");
  end
  if (DWELL_CYCLES < 1) begin : g_bad_dwell
    $error("word_scan_sequencer: DWELL_CYCLES must be at least 1");
  end

  state_t state, state_nxt;
  logic   go;        // begin a sweep at index 0
  logic   cap;       // capture the selected word
  logic   adv;       // word accepted, move to next index
  logic   fin;       // last word accepted
  logic   auto_go;   // dwell expired, behave as if start were pulsed

  // sel doubles as the sweep index: it only moves on entry to SELECT.
  assign busy = (state != IDLE);

`ifdef SCAN_AUTO_CYCLE_EN
  localparam int DWELL_W = $clog2(DWELL_CYCLES + 1);

  logic               armed;
  logic [DWELL_W-1:0] dwell_cnt;

  assign auto_go = armed && (state == IDLE) && (dwell_cnt == DWELL_W'(DWELL_CYCLES - 1));

  // Arm on a completed sweep, count idle cycles, disarm on abort or any sweep start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      dwell_cnt <= '0;
    end else if (abort || go) begin
      armed     <= 1'b0;
      dwell_cnt <= '0;
    end else if (fin) begin
      armed     <= 1'b1;
      dwell_cnt <= '0;
    end else if (armed && state == IDLE) begin
      dwell_cnt <= dwell_cnt + DWELL_W'(1);
    end
  end
`else
  assign auto_go = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath controls; abort overrides everything, including a handshake.
  always_comb begin
    state_nxt = state;
    go        = 1'b0;
    cap       = 1'b0;
    adv       = 1'b0;
    fin       = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start || auto_go) begin
            go        = 1'b1;
            state_nxt = SELECT;
          end
        end
        SELECT: begin
          cap       = 1'b1;
          state_nxt = PRESENT;
        end
        PRESENT: begin
          if (out_valid && out_ready) begin
            if (sel == LAST_IDX) begin
              fin       = 1'b1;
              state_nxt = IDLE;
            end else begin
              adv       = 1'b1;
              state_nxt = SELECT;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Select, capture register and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        sel       <= '0;
        out_valid <= 1'b0;
      end
      if (go) sel <= '0;
      if (cap) begin
        out_data  <= sel_data;
        out_index <= sel;
        out_valid <= 1'b1;
      end
      if (adv) begin
        out_valid <= 1'b0;
        sel       <= sel + SEL_W'(1);
      end
      if (fin) begin
        out_valid <= 1'b0;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: doc/word_scan_sequencer.md
# word_scan_sequencer

Sequences the 4-bit-select, 32-bit word multiplexer of the debug/display datapath. On request it sweeps the selector across all source words in index order, registers each selected word and streams it out over a valid/ready handshake to the downstream consumer (UART dumper, seven-segment refresher). It is the only driver of the multiplexer select.

## Interface
Parameters:
- NUM_SRC, 9, number of mux source words; indices 0..NUM_SRC-1
- SEL_W, 4, select width; 2**SEL_W >= NUM_SRC
- DATA_W, 32, word width
- DWELL_CYCLES, 1000, idle cycles between automatic sweeps (only with SCAN_AUTO_CYCLE_EN)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one full sweep; sampled only in IDLE
- abort  in  1  terminate sweep; honoured in every state
- sel  out  SEL_W  registered select to the mux
- sel_data  in  DATA_W  mux output, combinational from sel
- out_data  out  DATA_W  captured word
- out_index  out  SEL_W  index the captured word came from
- out_valid  out  1  out_data/out_index valid
- out_ready  in  1  consumer accepts when out_valid & out_ready
- busy  out  1  high in SELECT and PRESENT
- done  out  1  one-cycle pulse after last word accepted

## Operation
- States: IDLE, SELECT, PRESENT.
- IDLE: busy=0, out_valid=0, sel holds last value. start=1 (abort=0) -> sel<=0, idx<=0, go SELECT.
- SELECT: sel stable for the whole cycle; at clock edge out_data<=sel_data, out_index<=idx, out_valid<=1, go PRESENT.
- PRESENT: out_valid=1; out_data/out_index held unchanged until handshake. On out_valid & out_ready: out_valid<=0; if idx==NUM_SRC-1 -> done<=1 for one cycle, go IDLE; else idx<=idx+1, sel<=idx+1, go SELECT.
- abort=1 in any state: next state IDLE, out_valid<=0, done not pulsed, sel<=0. abort beats start and a same-cycle handshake (that word counts as delivered from the consumer's side; no further words).
- start while busy: ignored, no queuing.
- idx/sel never exceed NUM_SRC-1; no wrap within a sweep; next sweep restarts at 0.
- Reset (async assert): sel=0, out_data=0, out_index=0, out_valid=0, busy=0, done=0, state IDLE, dwell counter 0. Reset mid-sweep drops the sweep, no done.

## Timing
- start sampled at edge N -> SELECT during cycle N+1 with sel=0 -> out_valid=1 from edge N+2.
- Handshake at edge M (not last) -> SELECT in M+1 -> next out_valid from M+2: one bubble, peak 1 word / 2 cycles.
- Full sweep with out_ready tied high: 2*NUM_SRC cycles from start edge to last handshake; done high in the cycle after the last handshake (edge 2*NUM_SRC+1 for 9 sources = 19).
- out_ready asserted in the first cycle out_valid is high transfers that cycle.
- sel changes only on edges entering SELECT (or on abort/reset to 0).

## Configuration
- SCAN_AUTO_CYCLE_EN defined: after done (in IDLE, no abort since), a counter counts DWELL_CYCLES cycles and then starts a new sweep automatically as if start were pulsed; counter clears on start, abort, or reset. abort disables auto-restart until the next explicit start. Explicit start during dwell starts immediately.
- Not defined: no dwell counter; sweeps only on start; block returns and stays in IDLE after done.

## Test plan
- Reset then start, out_ready=1, sources word k = 0xA000_0000+k -> out_index 0..8 with those words, valid every other cycle, done one cycle at cycle 19, busy low after.
- out_ready held low 5 cycles on index 3 -> out_data=0xA000_0003 and out_index=3 stable all 5 cycles, sel stays 3, sweep then completes normally.
- abort asserted while PRESENT on index 4 -> out_valid=0 and busy=0 next cycle, sel=0, no done; later start restarts at index 0.
- start pulsed during sweep plus start with abort same cycle in IDLE -> no effect, single done per sweep, no sweep started.
- rst_n low mid-sweep (index 6) -> all outputs 0 immediately, IDLE; with SCAN_AUTO_CYCLE_EN and DWELL_CYCLES=10, second sweep begins 10 cycles after done without start.
